// File: rtl/alpha_recursion_unit.sv
`default_nettype none
// ============================================================================
// Module      : alpha_recursion_unit
// Description : Forward state-metric (alpha) recursion for an 8-state
//               max-log-MAP turbo decoder. One step updates all eight alphas
//               in a single cycle with saturating arithmetic. The result is
//               then normalised: either the new alpha0 is subtracted
//               (NORM_MODE=0), or the largest new alpha is subtracted
//               (NORM_MODE=1). A programmable block length bounds each run.
//
// Parameters  : W          signed metric width (>= 8)
//               BLK_LEN_W  block-length counter width
//               NORM_MODE  0: subtract new alpha0, 1: subtract max new alpha
//
// Ports       : clk, rst_n            clock, async active-low reset
//               start                 init alphas, sample blk_len/init_known
//               init_known            1: start state known, 0: all alphas 0
//               blk_len               trellis steps in the block
//               in_valid / in_ready   branch-metric handshake
//               m00, m01, m10, m11    signed branch metrics
//               alpha0..alpha7        registered state metrics
//               out_valid, out_index  alpha update strobe and step index
//               busy                  block in progress
//               done                  end-of-block pulse
//
// Revision    : 1.0 - initial release
// ============================================================================
module alpha_recursion_unit #(
    parameter int W         = 16,
    parameter int BLK_LEN_W = 13,
    parameter int NORM_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 init_known,
    input  logic [BLK_LEN_W-1:0] blk_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  m00,
    input  logic signed [W-1:0]  m01,
    input  logic signed [W-1:0]  m10,
    input  logic signed [W-1:0]  m11,
    output logic signed [W-1:0]  alpha0,
    output logic signed [W-1:0]  alpha1,
    output logic signed [W-1:0]  alpha2,
    output logic signed [W-1:0]  alpha3,
    output logic signed [W-1:0]  alpha4,
    output logic signed [W-1:0]  alpha5,
    output logic signed [W-1:0]  alpha6,
    output logic signed [W-1:0]  alpha7,
    output logic                 out_valid,
    output logic [BLK_LEN_W-1:0] out_index,
    output logic                 busy,
    output logic                 done
);

    // Known start state: every state except 0 starts at -2^(W-2).
    // This is well below 0, and it still leaves room for additions without wrap.
    localparam logic signed [W-1:0] C_INIT_NEG = {2'b11, {(W-2){1'b0}}};
    localparam logic signed [W-1:0] C_SAT_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] C_SAT_MIN  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic signed [W-1:0]   r_alpha [8];
    logic                  r_out_valid;
    logic                  r_done;
    logic [BLK_LEN_W-1:0]  r_count;
    logic [BLK_LEN_W-1:0]  r_blk_len;
    logic [BLK_LEN_W-1:0]  r_out_index;

    logic                  w_accept;
    logic                  w_final;
    logic                  w_done_nxt;
    logic [BLK_LEN_W-1:0]  w_count_inc;

    logic signed [W:0]     w_n [8];
    logic signed [W:0]     w_t;
    logic signed [W-1:0]   w_alpha_new [8];

    // ------------------------------------------------------------------
    // Add-compare-select. Both candidate sums are held in W+1 bits,
    // so the sums never wrap.
    // ------------------------------------------------------------------
    function automatic logic signed [W:0] f_acs(
        input logic signed [W-1:0] a_x,
        input logic signed [W-1:0] m_x,
        input logic signed [W-1:0] a_y,
        input logic signed [W-1:0] m_y
    );
        logic signed [W:0] s_x;
        logic signed [W:0] s_y;
        s_x = {a_x[W-1], a_x} + {m_x[W-1], m_x};
        s_y = {a_y[W-1], a_y} + {m_y[W-1], m_y};
        return (s_x > s_y) ? s_x : s_y;
    endfunction

    assign w_n[0] = f_acs(r_alpha[0], m00, r_alpha[1], m11);
    assign w_n[4] = f_acs(r_alpha[1], m00, r_alpha[0], m11);
    assign w_n[1] = f_acs(r_alpha[3], m01, r_alpha[2], m10);
    assign w_n[5] = f_acs(r_alpha[3], m10, r_alpha[2], m01);
    assign w_n[2] = f_acs(r_alpha[5], m10, r_alpha[4], m01);
    assign w_n[6] = f_acs(r_alpha[5], m01, r_alpha[4], m10);
    assign w_n[3] = f_acs(r_alpha[7], m00, r_alpha[6], m11);
    assign w_n[7] = f_acs(r_alpha[7], m11, r_alpha[6], m00);

    // ------------------------------------------------------------------
    // Normalisation reference
    // ------------------------------------------------------------------
    generate
        if (NORM_MODE == 1) begin : g_norm_max
            always_comb begin
                w_t = w_n[0];
                for (int i = 1; i < 8; i++) begin
                    if (w_n[i] > w_t) begin
                        w_t = w_n[i];
                    end
                end
            end
        end else begin : g_norm_alpha0
            assign w_t = w_n[0];
        end
    endgenerate

    // The difference of two (W+1)-bit values needs W+2 bits.
    // The difference saturates to W bits when its top three bits differ.
    generate
        for (genvar g = 0; g < 8; g++) begin : g_norm_lane
            logic signed [W+1:0] w_diff;
            logic                w_ovf;
            assign w_diff = {w_n[g][W], w_n[g]} - {w_t[W], w_t};
            assign w_ovf  = ~((&w_diff[W+1:W-1]) | ~(|w_diff[W+1:W-1]));
            assign w_alpha_new[g] = !w_ovf      ? w_diff[W-1:0] :
                                    w_diff[W+1] ? C_SAT_MIN     : C_SAT_MAX;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM: next state and handshake
    // ------------------------------------------------------------------
    assign w_count_inc = r_count + BLK_LEN_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        w_final     = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && (blk_len != '0)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (start) begin
                    // A restart takes priority, so any step offered in this cycle is dropped.
                    w_state_nxt = (blk_len != '0) ? S_RUN : S_IDLE;
                end else if (in_valid) begin
                    w_accept = 1'b1;
                    w_final  = (w_count_inc == r_blk_len);
                    if (w_final) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A zero-length block completes immediately after start.
        w_done_nxt = (start && (blk_len == '0)) || w_final;
    end

    // ------------------------------------------------------------------
    // State, metrics and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= '0;
            r_blk_len   <= '0;
            r_out_index <= '0;
            for (int i = 0; i < 8; i++) begin
                r_alpha[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_accept;
            r_done      <= w_done_nxt;
            if (start) begin
                r_count     <= '0;
                r_blk_len   <= blk_len;
                r_out_index <= '0;
                r_alpha[0]  <= '0;
                for (int i = 1; i < 8; i++) begin
                    r_alpha[i] <= init_known ? C_INIT_NEG : '0;
                end
            end else if (w_accept) begin
                r_count     <= w_count_inc;
                r_out_index <= w_count_inc;
                for (int i = 0; i < 8; i++) begin
                    r_alpha[i] <= w_alpha_new[i];
                end
            end
        end
    end

    assign alpha0    = r_alpha[0];
    assign alpha1    = r_alpha[1];
    assign alpha2    = r_alpha[2];
    assign alpha3    = r_alpha[3];
    assign alpha4    = r_alpha[4];
    assign alpha5    = r_alpha[5];
    assign alpha6    = r_alpha[6];
    assign alpha7    = r_alpha[7];
    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alpha_recursion_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alpha_recursion_unit
// Description : Self-checking bench for alpha_recursion_unit. It drives both
//               normalisation modes side by side from the same inputs and
//               checks each one against a trellis-table reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alpha_recursion_unit;

    localparam int W  = 16;
    localparam int BW = 13;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 init_known = 1'b0;
    logic [BW-1:0]        blk_len = '0;
    logic                 in_valid = 1'b0;
    logic signed [W-1:0]  m00 = '0, m01 = '0, m10 = '0, m11 = '0;

    logic [1:0]           rdy, ov, bsy, dn;
    logic [BW-1:0]        idx [2];
    logic signed [W-1:0]  al [2][8];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alpha_recursion_unit #(.W(W), .BLK_LEN_W(BW), .NORM_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .init_known(init_known),
        .blk_len(blk_len), .in_valid(in_valid), .in_ready(rdy[0]),
        .m00(m00), .m01(m01), .m10(m10), .m11(m11),
        .alpha0(al[0][0]), .alpha1(al[0][1]), .alpha2(al[0][2]), .alpha3(al[0][3]),
        .alpha4(al[0][4]), .alpha5(al[0][5]), .alpha6(al[0][6]), .alpha7(al[0][7]),
        .out_valid(ov[0]), .out_index(idx[0]), .busy(bsy[0]), .done(dn[0]));

    alpha_recursion_unit #(.W(W), .BLK_LEN_W(BW), .NORM_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .init_known(init_known),
        .blk_len(blk_len), .in_valid(in_valid), .in_ready(rdy[1]),
        .m00(m00), .m01(m01), .m10(m10), .m11(m11),
        .alpha0(al[1][0]), .alpha1(al[1][1]), .alpha2(al[1][2]), .alpha3(al[1][3]),
        .alpha4(al[1][4]), .alpha5(al[1][5]), .alpha6(al[1][6]), .alpha7(al[1][7]),
        .out_valid(ov[1]), .out_index(idx[1]), .busy(bsy[1]), .done(dn[1]));

    // ---------------- reference model ----------------
    // Trellis: new state s = max(alpha[PA]+metric[MA], alpha[PB]+metric[MB]).
    // Metric index 0..3 stands for m00, m01, m10, m11.
    int PA [8] = '{0, 3, 5, 7, 1, 3, 5, 7};
    int MA [8] = '{0, 1, 2, 0, 0, 2, 1, 3};
    int PB [8] = '{1, 2, 4, 6, 0, 2, 4, 6};
    int MB [8] = '{3, 2, 1, 3, 3, 1, 2, 0};

    int ma [2][8];
    int m_cnt, m_blen;
    bit m_run;
    bit e_ov, e_done;
    int e_idx;

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) ma[d][i] = 0;
        m_cnt = 0; m_blen = 0; m_run = 0; e_ov = 0; e_done = 0; e_idx = 0;
    endtask

    task automatic model_update(input bit st, input bit ik, input int bl,
                                input bit iv, input int mv [4]);
        int n [8];
        int t;
        if (st) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 8; i++) ma[d][i] = (i == 0 || !ik) ? 0 : -16384;
            m_cnt = 0; m_blen = bl; e_idx = 0; e_ov = 0;
            e_done = (bl == 0); m_run = (bl != 0);
        end else if (m_run && iv) begin
            for (int d = 0; d < 2; d++) begin
                for (int s = 0; s < 8; s++) begin
                    int x, y;
                    x = ma[d][PA[s]] + mv[MA[s]];
                    y = ma[d][PB[s]] + mv[MB[s]];
                    n[s] = (x > y) ? x : y;
                end
                t = n[0];
                if (d == 1)
                    for (int s = 1; s < 8; s++) if (n[s] > t) t = n[s];
                for (int s = 0; s < 8; s++) ma[d][s] = clamp16(n[s] - t);
            end
            m_cnt++; e_idx = m_cnt; e_ov = 1;
            e_done = (m_cnt == m_blen);
            if (e_done) m_run = 0;
        end else begin
            e_ov = 0; e_done = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int d, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0d, expected %0d", nm, d, act, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) chk($sformatf("alpha%0d", i), d, 32'(al[d][i]), ma[d][i]);
            chk("out_valid", d, {31'd0, ov[d]}, {31'd0, e_ov});
            chk("done", d, {31'd0, dn[d]}, {31'd0, e_done});
            chk("busy", d, {31'd0, bsy[d]}, {31'd0, m_run});
            chk("in_ready", d, {31'd0, rdy[d]}, {31'd0, m_run});
            chk("out_index", d, {19'd0, idx[d]}, e_idx);
        end
    endtask

    // One clock cycle: drive inputs, advance model, sample 1 time unit after the edge.
    task automatic cyc(input bit st, input bit ik, input int bl, input bit iv,
                       input int a, input int b, input int c, input int e);
        int mv [4];
        mv[0] = a; mv[1] = b; mv[2] = c; mv[3] = e;
        start = st; init_known = ik; blk_len = BW'(bl); in_valid = iv;
        m00 = a[15:0]; m01 = b[15:0]; m10 = c[15:0]; m11 = e[15:0];
        model_update(st, ik, bl, iv, mv);
        @(posedge clk);
        #1;
        check_all();
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rstep();
        int r [4];
        for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 5))
                0:       r[k] = 32767;
                1:       r[k] = -32768;
                default: r[k] = int'($urandom_range(0, 65535)) - 32768;
            endcase
        end
        cyc(0, 0, 0, 1, r[0], r[1], r[2], r[3]);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit ik;
        int m [4];      // m00, m01, m10, m11
        int e0 [8];     // expected alphas, alpha0-relative normalisation
        int e1 [8];     // expected alphas, max-relative normalisation
    } vec_t;

    vec_t vt [3];

    initial begin
        vt[0].ik = 1; vt[0].m = '{10, 0, 0, -10};
        vt[0].e0 = '{0, -16394, -16394, -16384, -20, -16394, -16394, -16384};
        vt[0].e1 = '{0, -16394, -16394, -16384, -20, -16394, -16394, -16384};
        vt[1].ik = 0; vt[1].m = '{32767, -32768, -32768, -32768};
        vt[1].e0 = '{0, -32768, -32768, 0, 0, -32768, -32768, 0};
        vt[1].e1 = '{0, -32768, -32768, 0, 0, -32768, -32768, 0};
        vt[2].ik = 0; vt[2].m = '{0, 5, 0, 0};
        vt[2].e0 = '{0, 5, 5, 0, 0, 5, 5, 0};
        vt[2].e1 = '{-5, 0, 0, -5, -5, 0, 0, -5};

        model_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all();                                   // reset state

        // Single-step blocks from the table
        for (int v = 0; v < 3; v++) begin
            cyc(1, vt[v].ik, 1, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 1, vt[v].m[0], vt[v].m[1], vt[v].m[2], vt[v].m[3]);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("tbl%0d_m0_a%0d", v, i), 0, 32'(al[0][i]), vt[v].e0[i]);
                chk($sformatf("tbl%0d_m1_a%0d", v, i), 1, 32'(al[1][i]), vt[v].e1[i]);
            end
            chk("tbl_done", 0, {31'd0, dn[0]}, 1);
            cyc(0, 0, 0, 1, 1, 2, 3, 4);                // extra step after done is ignored
            chk("tbl_busy_after", 0, {31'd0, bsy[0]}, 0);
        end

        // blk_len=4 with 2-cycle gaps; then a 5th in_valid is ignored
        cyc(1, 1, 4, 0, 0, 0, 0, 0);
        for (int s = 0; s < 4; s++) begin
            cyc(0, 0, 0, 1, 7 * s, -3, 11, -s);
            chk("gap_index", 0, {19'd0, idx[0]}, s + 1);
            chk("gap_done", 0, {31'd0, dn[0]}, (s == 3) ? 1 : 0);
            idle(2);
        end
        cyc(0, 0, 0, 1, 5, 5, 5, 5);

        // Restart after 2 of 5 steps, start coincident with in_valid
        cyc(1, 0, 5, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 100, -50, 20, 3);
        cyc(0, 0, 0, 1, -7, 40, 0, 9);
        cyc(1, 1, 5, 1, 300, 300, 300, 300);
        chk("restart_index", 0, {19'd0, idx[0]}, 0);
        for (int s = 0; s < 5; s++) rstep();
        chk("restart_done", 1, {31'd0, dn[1]}, 1);

        // Zero-length block
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        chk("zero_len_done", 0, {31'd0, dn[0]}, 1);
        idle(1);

        // Asynchronous reset mid-block
        cyc(1, 0, 6, 0, 0, 0, 0, 0);
        rstep(); rstep();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(0, 0, 0, 1, 9, 9, 9, 9);                   // in_valid in IDLE is ignored

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            bit st;
            st = (!m_run && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 59) == 0);
            if (st) begin
                cyc(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)), 1, 2, 3, 4);
            end else if ($urandom_range(0, 2) != 0) begin
                rstep();
            end else begin
                idle(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
